// File: rtl/commit_mon_pkg.sv
// commit_mon_pkg: state encoding and small helpers shared by the commit monitor blocks
package commit_mon_pkg;

    localparam int MAX_CHANNELS = 8;
    localparam int SLOT_CNT_W   = 4;

    typedef enum logic [1:0] {
        RUN,
        HALT_PEND,
        HALTED,
        TIMED_OUT
    } cm_state_e;

    // Counts the set bits among the lowest `width` positions of `bits`.
    function automatic logic [SLOT_CNT_W-1:0] popcount(input logic [MAX_CHANNELS-1:0] bits, input int width);
        logic [SLOT_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_CHANNELS; i++)
            if (i < width) n = n + SLOT_CNT_W'(bits[i]);
        return n;
    endfunction

    function automatic int cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/commit_prefix_count.sv
// commit_prefix_count: per-slot exclusive count of valid lower slots, plus the group total
module commit_prefix_count
    import commit_mon_pkg::*;
#(
    parameter int CHANNELS = 2
) (
    input  logic [CHANNELS-1:0]            valid,
    output logic [CHANNELS*SLOT_CNT_W-1:0] prefix,
    output logic [SLOT_CNT_W-1:0]          total
);

    logic [MAX_CHANNELS-1:0] bits;

    assign bits  = MAX_CHANNELS'(valid);
    assign total = popcount(bits, CHANNELS);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
        assign prefix[i*SLOT_CNT_W +: SLOT_CNT_W] = popcount(bits, i);
    end

endmodule

// File: rtl/commit_monitor.sv
// commit_monitor: numbers retiring instructions, detects the self-loop halt idiom,
// and flags commit stalls and malformed commit groups.
module commit_monitor
    import commit_mon_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int XLEN       = 32,
    parameter int ORDER_W    = 64,
    parameter int HALT_DELAY = 2,
    parameter int TIMEOUT    = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         commit_valid,
    input  logic [CHANNELS*XLEN-1:0]    commit_pc_rdata,
    input  logic [CHANNELS*XLEN-1:0]    commit_pc_wdata,
    output logic [CHANNELS*ORDER_W-1:0] commit_order,
    output logic [ORDER_W-1:0]          order_count,
    output logic                        halt,
    output logic                        timeout,
    output logic                        order_error
);

    localparam int IDLE_W  = cnt_width(TIMEOUT);
    localparam int DELAY_W = cnt_width(HALT_DELAY);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
    localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(HALT_DELAY - 1);

    cm_state_e                      state, state_next;
    logic [IDLE_W-1:0]              idle_cnt, idle_next;
    logic [DELAY_W-1:0]             delay_cnt, delay_next;
    logic [ORDER_W-1:0]             order_next;
    logic [CHANNELS*SLOT_CNT_W-1:0] prefix;
    logic [SLOT_CNT_W-1:0]          total;
    logic [CHANNELS:0]              valid_ext;
    logic                           any_commit, contiguous, detect, counting, error_next;

    commit_prefix_count #(.CHANNELS(CHANNELS)) u_prefix (
        .valid  (commit_valid),
        .prefix (prefix),
        .total  (total)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_order
        assign commit_order[i*ORDER_W +: ORDER_W] = order_count + ORDER_W'(prefix[i*SLOT_CNT_W +: SLOT_CNT_W]);
    end

    // A legal group is a run of ones from slot 0, so adding one leaves a single set bit.
    assign valid_ext  = {1'b0, commit_valid};
    assign contiguous = (valid_ext & (valid_ext + (CHANNELS+1)'(1))) == '0;
    assign any_commit = |commit_valid;
    assign counting   = (state == RUN) || (state == HALT_PEND);
    assign order_next = counting ? order_count + ORDER_W'(total) : order_count;
    assign error_next = order_error | (counting & ~contiguous);

    always_comb begin
        detect = 1'b0;
        for (int i = 0; i < CHANNELS; i++)
            detect = detect | (commit_valid[i] &&
                     (commit_pc_rdata[i*XLEN +: XLEN] == commit_pc_wdata[i*XLEN +: XLEN]));
    end

    always_comb begin
        state_next = state;
        idle_next  = idle_cnt;
        delay_next = delay_cnt;
        case (state)
            RUN: begin
                idle_next  = any_commit ? '0 : idle_cnt + IDLE_W'(1);
                delay_next = detect ? DELAY_LOAD : delay_cnt;
                if (detect)
                    state_next = HALT_PEND;
                else if (!any_commit && idle_cnt == IDLE_LAST)
                    state_next = TIMED_OUT;
            end
            HALT_PEND: begin
                delay_next = (delay_cnt == '0) ? delay_cnt : delay_cnt - DELAY_W'(1);
                if (delay_cnt == '0)
                    state_next = HALTED;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            idle_cnt    <= '0;
            delay_cnt   <= '0;
            order_count <= '0;
            order_error <= 1'b0;
            halt        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            idle_cnt    <= idle_next;
            delay_cnt   <= delay_next;
            order_count <= order_next;
            order_error <= error_next;
            halt        <= state_next == HALTED;
            timeout     <= state_next == TIMED_OUT;
        end
    end

endmodule

// File: tb/tb_commit_monitor.sv
// tb_commit_monitor: directed scenarios plus randomized traffic checked against an
// edge-counting reference model of the commit monitor.
module tb_commit_monitor;

    localparam int CH   = 4;
    localparam int XLEN = 32;
    localparam int OW   = 4;
    localparam int HD   = 2;
    localparam int TO   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [CH-1:0]     commit_valid = '0;
    logic [CH*XLEN-1:0] commit_pc_rdata = '0;
    logic [CH*XLEN-1:0] commit_pc_wdata = '0;
    logic [CH*OW-1:0]  commit_order;
    logic [OW-1:0]     order_count;
    logic              halt, timeout, order_error;

    int checks = 0;
    int failures = 0;

    // Reference model: edges are numbered from the first clock after reset release.
    int       edge_no, last_commit, halt_edge;
    logic [OW-1:0] m_count;
    bit       m_err, m_pend, m_halt, m_to;

    always #5 clk = ~clk;

    commit_monitor #(
        .CHANNELS(CH), .XLEN(XLEN), .ORDER_W(OW), .HALT_DELAY(HD), .TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_pc_rdata(commit_pc_rdata),
        .commit_pc_wdata(commit_pc_wdata),
        .commit_order   (commit_order),
        .order_count    (order_count),
        .halt           (halt),
        .timeout        (timeout),
        .order_error    (order_error)
    );

    function automatic int ones_below(input logic [CH-1:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [OW-1:0] exp_order(input int slot);
        return m_count + OW'(ones_below(commit_valid, slot));
    endfunction

    function automatic logic [OW-1:0] got_order(input int slot);
        return commit_order[slot*OW +: OW];
    endfunction

    task automatic drive(input logic [CH-1:0] v, input int halt_slot);
        logic [XLEN-1:0] pc;
        commit_valid = v;
        for (int i = 0; i < CH; i++) begin
            pc = (i == halt_slot) ? XLEN'(32'h60) : XLEN'($urandom) & ~XLEN'(3);
            commit_pc_rdata[i*XLEN +: XLEN] = pc;
            commit_pc_wdata[i*XLEN +: XLEN] = (i == halt_slot) ? pc : pc + XLEN'(4);
        end
        #1;
    endtask

    task automatic tick();
        bit det;
        int n;
        @(posedge clk);
        det = 1'b0;
        for (int i = 0; i < CH; i++)
            if (commit_valid[i] && commit_pc_rdata[i*XLEN +: XLEN] == commit_pc_wdata[i*XLEN +: XLEN])
                det = 1'b1;
        n = ones_below(commit_valid, CH);
        if (!m_halt && !m_to) begin
            m_count = m_count + OW'(n);
            if (commit_valid != CH'((1 << n) - 1)) m_err = 1'b1;
            if (m_pend) m_halt = (edge_no == halt_edge);
            else if (det) begin
                m_pend = 1'b1;
                halt_edge = edge_no + HD;
            end
            else if (n != 0) last_commit = edge_no;
            else if (edge_no - last_commit >= TO) m_to = 1'b1;
        end
        edge_no++;
        #1;
    endtask

    task automatic model_clear();
        edge_no = 0;
        last_commit = -1;
        halt_edge = 0;
        m_count = '0;
        m_err = 1'b0;
        m_pend = 1'b0;
        m_halt = 1'b0;
        m_to = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        drive(4'b0111, -1);
        rst = 1'b0;
        #1;
        checks++;
        if (order_count !== '0) begin failures++; $display("FAIL reset_order_count got %0d exp 0", order_count); end
        checks++;
        if ({halt, timeout, order_error} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b exp 000", {halt, timeout, order_error}); end
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (got_order(i) !== OW'(ones_below(4'b0111, i))) begin failures++; $display("FAIL reset_order slot%0d got %0d exp %0d", i, got_order(i), ones_below(4'b0111, i)); end
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_order_basic();
        reset_dut();
        for (int c = 0; c < 4; c++) begin
            drive(c < 3 ? 4'b0011 : 4'b0001, -1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_order(i) !== OW'(2*c + i)) begin failures++; $display("FAIL basic_order c%0d slot%0d got %0d exp %0d", c, i, got_order(i), 2*c + i); end
            end
            tick();
        end
        checks++;
        if (order_count !== OW'(7)) begin failures++; $display("FAIL basic_count got %0d exp 7", order_count); end
        checks++;
        if (order_error !== 1'b0) begin failures++; $display("FAIL basic_error got %b exp 0", order_error); end
    endtask

    task automatic test_halt();
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            drive(4'b0001, -1);
            tick();
        end
        drive(4'b0011, 1);
        tick();
        checks++;
        if (halt !== 1'b0) begin failures++; $display("FAIL halt_early c10 got %b exp 0", halt); end
        for (int c = 11; c <= 13; c++) begin
            drive('0, -1);
            tick();
            checks++;
            if (halt !== (c >= 12)) begin failures++; $display("FAIL halt_timing c%0d got %b exp %b", c, halt, c >= 12); end
        end
        for (int c = 0; c < 3; c++) begin
            drive(4'b0011, 0);
            checks++;
            if (got_order(1) !== OW'(13)) begin failures++; $display("FAIL halted_order got %0d exp 13", got_order(1)); end
            tick();
            checks++;
            if (order_count !== OW'(12) || halt !== 1'b1) begin failures++; $display("FAIL halted_frozen count %0d halt %b exp 12 1", order_count, halt); end
        end
    endtask

    task automatic test_order_error();
        reset_dut();
        drive(4'b0011, -1);
        tick();
        checks++;
        if (order_error !== 1'b0) begin failures++; $display("FAIL err_legal got %b exp 0", order_error); end
        drive(4'b0010, -1);
        checks++;
        if (order_error !== 1'b0) begin failures++; $display("FAIL err_before_edge got %b exp 0", order_error); end
        tick();
        checks++;
        if (order_error !== 1'b1 || order_count !== OW'(3)) begin failures++; $display("FAIL err_set err %b count %0d exp 1 3", order_error, order_count); end
        drive(4'b0111, -1);
        tick();
        checks++;
        if (order_error !== 1'b1 || order_count !== OW'(6)) begin failures++; $display("FAIL err_sticky err %b count %0d exp 1 6", order_error, order_count); end
    endtask

    task automatic test_timeout();
        reset_dut();
        for (int c = 0; c <= 5; c++) begin
            drive(4'b0001, -1);
            tick();
        end
        for (int c = 6; c <= 14; c++) begin
            drive('0, -1);
            tick();
            checks++;
            if (timeout !== (c >= 13) || halt !== 1'b0) begin failures++; $display("FAIL timeout_timing c%0d timeout %b halt %b exp %b 0", c, timeout, halt, c >= 13); end
        end
        drive(4'b0011, 0);
        tick();
        checks++;
        if (order_count !== OW'(6) || halt !== 1'b0 || timeout !== 1'b1) begin failures++; $display("FAIL timeout_terminal count %0d halt %b timeout %b exp 6 0 1", order_count, halt, timeout); end
    endtask

    task automatic test_reset_mid_halt();
        reset_dut();
        drive(4'b0010, -1);
        tick();
        drive(4'b0001, 0);
        tick();
        checks++;
        if (order_error !== 1'b1 || order_count !== OW'(2)) begin failures++; $display("FAIL midrst_pre err %b count %0d exp 1 2", order_error, order_count); end
        drive('0, -1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({order_count, halt, timeout, order_error} !== '0) begin failures++; $display("FAIL midrst_async count %0d halt %b timeout %b err %b exp all 0", order_count, halt, timeout, order_error); end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        for (int c = 0; c < 8; c++) begin
            drive(4'b0001, -1);
            tick();
            checks++;
            if (halt !== 1'b0 || order_count !== OW'(c + 1)) begin failures++; $display("FAIL midrst_after c%0d halt %b count %0d exp 0 %0d", c, halt, order_count, c + 1); end
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        repeat (14) begin
            drive(4'b0001, -1);
            tick();
        end
        checks++;
        if (order_count !== OW'(14)) begin failures++; $display("FAIL wrap_preload got %0d exp 14", order_count); end
        drive(4'b0011, -1);
        checks++;
        if (got_order(0) !== OW'(14) || got_order(1) !== OW'(15)) begin failures++; $display("FAIL wrap_order got %0d %0d exp 14 15", got_order(0), got_order(1)); end
        tick();
        checks++;
        if (order_count !== OW'(0)) begin failures++; $display("FAIL wrap_count got %0d exp 0", order_count); end
    endtask

    task automatic test_random();
        logic [CH-1:0] v;
        int idle_pct, r, hs;
        for (int ep = 0; ep < 8; ep++) begin
            idle_pct = (ep % 2 == 1) ? 85 : 25;
            reset_dut();
            for (int c = 0; c < 60; c++) begin
                r = int'($urandom_range(99));
                if (r < idle_pct) v = '0;
                else if (r < idle_pct + (100 - idle_pct) / 5) v = CH'($urandom);
                else v = CH'((1 << $urandom_range(CH, 1)) - 1);
                hs = ($urandom_range(39) == 0) ? int'($urandom_range(CH - 1)) : -1;
                drive(v, hs);
                for (int i = 0; i < CH; i++) begin
                    checks++;
                    if (got_order(i) !== exp_order(i)) begin failures++; $display("FAIL rand_order ep%0d c%0d slot%0d got %0d exp %0d", ep, c, i, got_order(i), exp_order(i)); end
                end
                tick();
                checks++;
                if (order_count !== m_count) begin failures++; $display("FAIL rand_count ep%0d c%0d got %0d exp %0d", ep, c, order_count, m_count); end
                checks++;
                if ({halt, timeout, order_error} !== {m_halt, m_to, m_err}) begin failures++; $display("FAIL rand_flags ep%0d c%0d got %b exp %b", ep, c, {halt, timeout, order_error}, {m_halt, m_to, m_err}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_order_basic();
        test_halt();
        test_order_error();
        test_timeout();
        test_reset_mid_halt();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
